uart_cmd_responder: RTL and testbench



---
 rtl/uart_cmd_responder.sv | 199 +++++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_responder.sv
// ============================================================================
//  Module      : uart_cmd_responder
//  Description : Device-end command parser for the UART link. Accepts
//                write (op, addr, data) and read (op, addr) commands against
//                an internal register file, answers with ACK, NAK or read
//                data via the transmitter handshake, counts dropped bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_cmd_responder #(
  parameter int         ADDR_WIDTH  = 4,
  parameter logic [7:0] WR_CMD      = 8'hAA,
  parameter logic [7:0] RD_CMD      = 8'hBB,
  parameter logic [7:0] ACK_BYTE    = 8'h5A,
  parameter logic [7:0] NAK_BYTE    = 8'hEE,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  input  logic       rx_par_err,
  input  logic       rx_frame_err,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_data_valid,
  output logic       cmd_done,
  output logic [7:0] err_cnt
);

  localparam int                c_DEPTH   = 2 ** ADDR_WIDTH;
  localparam int                c_TO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_ADDR = 3'd1,
    S_GET_DATA = 3'd2,
    S_SEND     = 3'd3,
    S_GUARD    = 3'd4
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_is_wr, w_is_wr_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
  logic [7:0]              r_tx_data, w_tx_data_nxt;
  logic [c_TO_W-1:0]       r_to_cnt, w_to_cnt_nxt;
  logic                    r_guard, w_guard_nxt;
  logic [7:0]              r_err_cnt;
  logic                    w_err_inc;
  logic                    w_reg_we;
  logic [7:0]              r_regs [c_DEPTH];

  logic                    w_rx_bad;
  logic                    w_rx_ok;
  logic                    w_addr_bad;
  logic [ADDR_WIDTH-1:0]   w_addr_idx;

  assign w_rx_bad   = rx_data_valid & (rx_par_err | rx_frame_err);
  assign w_rx_ok    = rx_data_valid & ~(rx_par_err | rx_frame_err);
  // Any set bit above the index field makes the address out of range.
  assign w_addr_bad = |(rx_data >> ADDR_WIDTH);
  assign w_addr_idx = rx_data[ADDR_WIDTH-1:0];

  assign tx_data = r_tx_data;
  assign err_cnt = r_err_cnt;

  // Next-state, response loading, error accounting and the TX strobe.
  always_comb begin
    w_state_nxt   = r_state;
    w_is_wr_nxt   = r_is_wr;
    w_addr_nxt    = r_addr;
    w_tx_data_nxt = r_tx_data;
    w_to_cnt_nxt  = '0;
    w_guard_nxt   = 1'b0;
    w_err_inc     = 1'b0;
    w_reg_we      = 1'b0;
    tx_data_valid = 1'b0;
    cmd_done      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_rx_bad) begin
          w_err_inc = 1'b1;
        end else if (w_rx_ok) begin
          if (rx_data == WR_CMD || rx_data == RD_CMD) begin
            w_is_wr_nxt = (rx_data == WR_CMD);
            w_state_nxt = S_GET_ADDR;
          end else begin
            w_tx_data_nxt = NAK_BYTE;
            w_state_nxt   = S_SEND;
          end
        end
      end

      S_GET_ADDR: begin
        if (w_rx_bad) begin
          w_err_inc   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_rx_ok) begin
          if (w_addr_bad) begin
            w_tx_data_nxt = NAK_BYTE;
            w_state_nxt   = S_SEND;
          end else if (!r_is_wr) begin
            // Read data is frozen here so it cannot change while queued.
            w_tx_data_nxt = r_regs[w_addr_idx];
            w_state_nxt   = S_SEND;
          end else begin
            w_addr_nxt  = w_addr_idx;
            w_state_nxt = S_GET_DATA;
          end
        end else if (r_to_cnt == c_TO_LAST) begin
          w_err_inc   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 1'b1;
        end
      end

      S_GET_DATA: begin
        if (w_rx_bad) begin
          w_err_inc   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_rx_ok) begin
          w_reg_we      = 1'b1;
          w_tx_data_nxt = ACK_BYTE;
          w_state_nxt   = S_SEND;
        end else if (r_to_cnt == c_TO_LAST) begin
          w_err_inc   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 1'b1;
        end
      end

      S_SEND: begin
        w_err_inc = rx_data_valid;
        if (!tx_busy) begin
          tx_data_valid = 1'b1;
          cmd_done      = 1'b1;
          w_state_nxt   = S_GUARD;
        end
      end

      S_GUARD: begin
        // Two cycles that ignore tx_busy while the transmitter raises it.
        w_err_inc = rx_data_valid;
        if (r_guard) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_guard_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Control state, response byte, timeout and saturating error counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_is_wr   <= 1'b0;
      r_addr    <= '0;
      r_tx_data <= 8'h00;
      r_to_cnt  <= '0;
      r_guard   <= 1'b0;
      r_err_cnt <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_is_wr   <= w_is_wr_nxt;
      r_addr    <= w_addr_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_guard   <= w_guard_nxt;
      if (w_err_inc && r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  // Register file, written only by a completed write command.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else if (w_reg_we) begin
      r_regs[r_addr] <= rx_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_responder.sv
// ============================================================================
//  Module      : tb_uart_cmd_responder
//  Description : Self-checking bench for uart_cmd_responder: table of
//                command vectors plus directed multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_cmd_responder;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_valid = 1'b0;
  logic       rx_par_err = 1'b0;
  logic       rx_frame_err = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       cmd_done;
  logic [7:0] err_cnt;

  uart_cmd_responder dut (
    .CLK           (CLK),
    .RST           (RST),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_par_err    (rx_par_err),
    .rx_frame_err  (rx_frame_err),
    .tx_busy       (tx_busy),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .cmd_done      (cmd_done),
    .err_cnt       (err_cnt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_strobe = 0;
  int strobe_cyc = -1;
  logic [7:0] last_resp = 8'h00;

  always @(posedge CLK) cyc <= cyc + 1;

  // Strobe monitor: record every response and check the handshake rules.
  always @(negedge CLK) begin
    if (RST && (tx_data_valid || cmd_done)) begin
      checks++;
      if (tx_data_valid !== cmd_done) begin
        errors++;
        $display("FAIL strobe_pair: tx_data_valid=%b cmd_done=%b required equal", tx_data_valid, cmd_done);
      end
      checks++;
      if (tx_busy && tx_data_valid) begin
        errors++;
        $display("FAIL strobe_busy: tx_data_valid=1 while tx_busy=1, required 0");
      end
      if (tx_data_valid) begin
        n_strobe++;
        strobe_cyc = cyc;
        last_resp  = tx_data;
      end
    end
  end

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h required %02h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drive up to three bytes back-to-back; errk flags the last byte
  // (1 = parity error, 2 = framing error). Returns the sampling edge index.
  task automatic send_bytes(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int n, input int errk,
                            output int last_edge);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = (i == 0) ? b0 : ((i == 1) ? b1 : b2);
      rx_data       = b;
      rx_data_valid = 1'b1;
      rx_par_err    = (i == n - 1) && (errk == 1);
      rx_frame_err  = (i == n - 1) && (errk == 2);
      @(posedge CLK);
      #1;
      last_edge = cyc;
    end
    rx_data_valid = 1'b0;
    rx_par_err    = 1'b0;
    rx_frame_err  = 1'b0;
  endtask

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         n;
    int         errk;
    logic       exp_resp;
    logic [7:0] exp_byte;
    logic [7:0] exp_err;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  initial begin
    int le;
    int n0;
    int busy_edge;

    vecs[0]  = '{8'hAA, 8'h03, 8'h5C, 3, 0, 1'b1, 8'h5A, 8'h00}; // write reg3
    vecs[1]  = '{8'hBB, 8'h03, 8'h00, 2, 0, 1'b1, 8'h5C, 8'h00}; // read reg3
    vecs[2]  = '{8'hBB, 8'h07, 8'h00, 2, 0, 1'b1, 8'h00, 8'h00}; // never written
    vecs[3]  = '{8'h42, 8'h00, 8'h00, 1, 0, 1'b1, 8'hEE, 8'h00}; // bad opcode
    vecs[4]  = '{8'hBB, 8'h10, 8'h00, 2, 0, 1'b1, 8'hEE, 8'h00}; // bad addr bit 4
    vecs[5]  = '{8'hAA, 8'h03, 8'h99, 3, 1, 1'b0, 8'h00, 8'h01}; // parity on data
    vecs[6]  = '{8'hBB, 8'h03, 8'h00, 2, 0, 1'b1, 8'h5C, 8'h01}; // reg3 unchanged
    vecs[7]  = '{8'hAA, 8'h1F, 8'h00, 2, 0, 1'b1, 8'hEE, 8'h01}; // bad write addr
    vecs[8]  = '{8'hAA, 8'h0F, 8'hFF, 3, 0, 1'b1, 8'h5A, 8'h01}; // top address
    vecs[9]  = '{8'hBB, 8'h0F, 8'h00, 2, 0, 1'b1, 8'hFF, 8'h01};
    vecs[10] = '{8'hBB, 8'h00, 8'h00, 1, 2, 1'b0, 8'h00, 8'h02}; // framing in IDLE
    vecs[11] = '{8'hAA, 8'h03, 8'h00, 2, 1, 1'b0, 8'h00, 8'h03}; // parity on addr
    vecs[12] = '{8'hBB, 8'h03, 8'h00, 2, 0, 1'b1, 8'h5C, 8'h03};
    vecs[13] = '{8'hBB, 8'h80, 8'h00, 2, 0, 1'b1, 8'hEE, 8'h03}; // bad addr bit 7

    // Reset state
    tick(3);
    chk8("reset_tx_data", tx_data, 8'h00);
    chk8("reset_tx_valid", {7'd0, tx_data_valid}, 8'h00);
    chk8("reset_cmd_done", {7'd0, cmd_done}, 8'h00);
    chk8("reset_err_cnt", err_cnt, 8'h00);
    RST = 1'b1;
    tick(2);

    // Table-driven command vectors
    for (int i = 0; i < NVEC; i++) begin
      n0 = n_strobe;
      send_bytes(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].n, vecs[i].errk, le);
      tick(8);
      chki($sformatf("vec%0d_resp_count", i), n_strobe - n0, vecs[i].exp_resp ? 1 : 0);
      if (vecs[i].exp_resp) begin
        chk8($sformatf("vec%0d_resp_byte", i), last_resp, vecs[i].exp_byte);
        chki($sformatf("vec%0d_latency", i), strobe_cyc, le);
      end
      chk8($sformatf("vec%0d_err_cnt", i), err_cnt, vecs[i].exp_err);
    end

    // Bad write address followed immediately by a byte that lands in SEND
    n0 = n_strobe;
    send_bytes(8'hAA, 8'h1F, 8'h77, 3, 0, le);
    tick(8);
    chki("b2b_resp_count", n_strobe - n0, 1);
    chk8("b2b_resp_byte", last_resp, 8'hEE);
    chk8("b2b_err_cnt", err_cnt, 8'h04);

    // Transmitter backpressure with a byte dropped while in SEND
    tx_busy = 1'b1;
    n0 = n_strobe;
    send_bytes(8'hBB, 8'h03, 8'h00, 2, 0, le);
    tick(3);
    send_bytes(8'h11, 8'h00, 8'h00, 1, 0, le);
    tick(195);
    chki("busy_no_strobe", n_strobe - n0, 0);
    chk8("busy_drop_err_cnt", err_cnt, 8'h05);
    tx_busy = 1'b0;
    busy_edge = cyc;
    tick(8);
    chki("busy_resp_count", n_strobe - n0, 1);
    chk8("busy_resp_byte", last_resp, 8'h5C);
    chki("busy_strobe_cycle", strobe_cyc, busy_edge);

    // Inter-byte timeout in GET_DATA
    n0 = n_strobe;
    send_bytes(8'hAA, 8'h05, 8'h00, 2, 0, le);
    tick(4095);
    chk8("timeout_not_yet", err_cnt, 8'h05);
    tick(1);
    chk8("timeout_err_cnt", err_cnt, 8'h06);
    chki("timeout_no_resp", n_strobe - n0, 0);
    send_bytes(8'h77, 8'h00, 8'h00, 1, 0, le);
    tick(8);
    chki("timeout_77_count", n_strobe - n0, 1);
    chk8("timeout_77_nak", last_resp, 8'hEE);
    send_bytes(8'hBB, 8'h05, 8'h00, 2, 0, le);
    tick(8);
    chk8("timeout_no_write", last_resp, 8'h00);
    chk8("timeout_err_final", err_cnt, 8'h06);

    // Error counter saturation
    n0 = n_strobe;
    for (int k = 0; k < 300; k++) begin
      send_bytes(8'h33, 8'h00, 8'h00, 1, 1, le);
    end
    tick(4);
    chk8("sat_err_cnt", err_cnt, 8'hFF);
    chki("sat_no_resp", n_strobe - n0, 0);

    // Reset in the middle of a write command
    send_bytes(8'hBB, 8'h03, 8'h00, 2, 0, le);
    tick(8);
    chk8("pre_reset_read", last_resp, 8'h5C);
    send_bytes(8'hAA, 8'h03, 8'h00, 2, 0, le);
    #2;
    RST = 1'b0;
    #1;
    chk8("mid_reset_tx_data", tx_data, 8'h00);
    chk8("mid_reset_err_cnt", err_cnt, 8'h00);
    chk8("mid_reset_valid", {7'd0, tx_data_valid}, 8'h00);
    tick(2);
    RST = 1'b1;
    tick(2);
    n0 = n_strobe;
    send_bytes(8'hBB, 8'h03, 8'h00, 2, 0, le);
    tick(8);
    chki("post_reset_count", n_strobe - n0, 1);
    chk8("post_reset_reg3", last_resp, 8'h00);
    send_bytes(8'hBB, 8'h0F, 8'h00, 2, 0, le);
    tick(8);
    chk8("post_reset_reg15", last_resp, 8'h00);
    chk8("post_reset_err_cnt", err_cnt, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
